// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and types, also used by VGAController's coordinate decode.
// Pure declarations: no logic, no latency, no flow control.
package vga_pkg;
    localparam int H_VIS    = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_VIS    = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam int COORD_W  = 10;
    localparam int COLOR_W  = 12;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [COLOR_W-1:0] color_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic vis;
        logic frame;
    } tim_t;

    localparam tim_t TIM_IDLE = '{hs: 1'b1, vs: 1'b1, vis: 1'b0, frame: 1'b0};
endpackage

// File: rtl/vga_encoder_if.sv
// Encoder <-> controller/pin bundle: coordinates out, colour select back, sync/RGB/frame tick to pins.
// Free-running every pixel clock; no handshake and no backpressure.
interface vga_encoder_if;
    import vga_pkg::*;

    color_t     csel;
    coord_t     hcoord;
    coord_t     vcoord;
    logic       hsync;
    logic       vsync;
    logic [3:0] vga_r;
    logic [3:0] vga_g;
    logic [3:0] vga_b;
    logic       frame_start;

    modport master (
        input  csel,
        output hcoord, vcoord, hsync, vsync, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        output csel,
        input  hcoord, vcoord, hsync, vsync, vga_r, vga_g, vga_b, frame_start
    );
endinterface

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register (DEPTH 0..3) with synchronous reset to RST_VAL.
// Latency DEPTH clocks (DEPTH=0 is a plain wire); always advances, no backpressure.
module vga_delay_line #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic [WIDTH-1:0] i_dat,
    output logic [WIDTH-1:0] o_dat
);
    if (DEPTH == 0) begin : g_pass
        logic w_unused;
        assign w_unused = i_clk ^ i_srst;
        assign o_dat    = i_dat;
    end else begin : g_pipe
        logic [WIDTH-1:0] r_stage [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_srst) begin
                for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
            end else begin
                r_stage[0] <= i_dat;
                for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
            end
        end

        assign o_dat = r_stage[DEPTH-1];
    end
endmodule

// File: rtl/vga_encoder.sv
// VGA timing generator and pin stage; sync/blank/frame delayed CSEL_LAT+1 clocks to line up with CSEL.
// Pins at edge t+1+CSEL_LAT reflect the coordinate presented at edge t; free-running, no backpressure.
module vga_encoder
    import vga_pkg::*;
#(
    parameter int H_VIS    = vga_pkg::H_VIS,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_VIS    = vga_pkg::V_VIS,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP,
    parameter int CSEL_LAT = 1
) (
    input  logic          i_clk,
    input  logic          i_srst,
    vga_encoder_if.master io_vga
);
    localparam int H_TOTAL  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_FIRST = H_VIS + H_FP;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_VIS + V_FP;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;

    if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_total
        $error("vga_encoder: H_TOT/V_TOT do not fit the 10-bit counters");
    end
    if (CSEL_LAT < 0 || CSEL_LAT > 3) begin : g_bad_lat
        $error("vga_encoder: CSEL_LAT must be 0..3");
    end

    coord_t r_h;
    coord_t r_v;
    tim_t   w_raw;
    tim_t   w_dly;
    logic   r_hsync;
    logic   r_vsync;
    logic   r_frame;
    color_t r_rgb;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_h <= '0;
            r_v <= '0;
        end else if (r_h == coord_t'(H_TOTAL - 1)) begin
            r_h <= '0;
            r_v <= (r_v == coord_t'(V_TOTAL - 1)) ? '0 : r_v + coord_t'(1);
        end else begin
            r_h <= r_h + coord_t'(1);
        end
    end

    always_comb begin
        w_raw       = TIM_IDLE;
        w_raw.hs    = !((r_h >= coord_t'(HS_FIRST)) && (r_h <= coord_t'(HS_LAST)));
        w_raw.vs    = !((r_v >= coord_t'(VS_FIRST)) && (r_v <= coord_t'(VS_LAST)));
        w_raw.vis   = (r_h < coord_t'(H_VIS)) && (r_v < coord_t'(V_VIS));
        w_raw.frame = (r_h == '0) && (r_v == '0);
    end

    // Matches the controller's CSEL latency so the decode meets its colour at the output register.
    vga_delay_line #(
        .WIDTH   ($bits(tim_t)),
        .DEPTH   (CSEL_LAT),
        .RST_VAL (TIM_IDLE)
    ) u_dly (
        .i_clk  (i_clk),
        .i_srst (i_srst),
        .i_dat  (w_raw),
        .o_dat  (w_dly)
    );

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_frame <= 1'b0;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_dly.hs;
            r_vsync <= w_dly.vs;
            r_frame <= w_dly.frame;
            r_rgb   <= w_dly.vis ? io_vga.csel : '0;
        end
    end

    assign io_vga.hcoord      = r_h;
    assign io_vga.vcoord      = r_v;
    assign io_vga.hsync       = r_hsync;
    assign io_vga.vsync       = r_vsync;
    assign io_vga.frame_start = r_frame;
    assign io_vga.vga_r       = r_rgb[11:8];
    assign io_vga.vga_g       = r_rgb[7:4];
    assign io_vga.vga_b       = r_rgb[3:0];
endmodule

// File: tb/tb_vga_encoder.sv
// Bench for vga_encoder: three shrunk-timing instances (CSEL_LAT 0/1/3) plus one full 640x480 instance,
// all compared every clock with an index-arithmetic reference model, plus table vectors and sequences.
module tb_vga_encoder;
    import vga_pkg::*;

    typedef struct {
        int hvis, hfp, hsync, hbp, vvis, vfp, vsync, vbp, lat;
        bit ramp;
    } cfg_t;

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [11:0] rgb;
    } pins_t;

    typedef struct {
        int    k;
        pins_t exp;
    } tv_t;

    logic  clk;
    logic  srst;
    int    k;
    int    n_vec;
    int    n_bad;
    cfg_t  cfg [4];
    string names [4];
    tv_t   tbl [13];

    vga_encoder_if vi0 ();
    vga_encoder_if vi1 ();
    vga_encoder_if vi3 ();
    vga_encoder_if vif ();

    vga_encoder #(.H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                  .CSEL_LAT(0)) u_l0 (.i_clk(clk), .i_srst(srst), .io_vga(vi0));
    vga_encoder #(.H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                  .CSEL_LAT(1)) u_l1 (.i_clk(clk), .i_srst(srst), .io_vga(vi1));
    vga_encoder #(.H_VIS(16), .H_FP(4), .H_SYNC(6), .H_BP(6), .V_VIS(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
                  .CSEL_LAT(3)) u_l3 (.i_clk(clk), .i_srst(srst), .io_vga(vi3));
    vga_encoder #(.CSEL_LAT(1)) u_full (.i_clk(clk), .i_srst(srst), .io_vga(vif));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int htot(cfg_t c);
        return c.hvis + c.hfp + c.hsync + c.hbp;
    endfunction

    function automatic int vtot(cfg_t c);
        return c.vvis + c.vfp + c.vsync + c.vbp;
    endfunction

    function automatic logic [11:0] color(cfg_t c, int h, int v);
        logic [9:0] hb;
        logic [9:0] vb;
        hb = 10'(h);
        vb = 10'(v);
        return c.ramp ? {hb[3:0], vb[3:0], 4'h5} : 12'hFFF;
    endfunction

    // k = clock edges since reset release (-1 while in reset); coordinate index k+1 is on the counters,
    // and the pins show the coordinate index k-lat.
    function automatic pins_t model(cfg_t c, int kk);
        int    ht, vt, hss, vss, n, h, v;
        pins_t p;
        ht    = htot(c);
        vt    = vtot(c);
        hss   = c.hvis + c.hfp;
        vss   = c.vvis + c.vfp;
        p.h   = 10'((kk + 1) % ht);
        p.v   = 10'(((kk + 1) / ht) % vt);
        p.hs  = 1'b1;
        p.vs  = 1'b1;
        p.fs  = 1'b0;
        p.rgb = 12'h000;
        n     = kk - c.lat;
        if (n >= 0) begin
            h    = n % ht;
            v    = (n / ht) % vt;
            p.hs = !(h >= hss && h < hss + c.hsync);
            p.vs = !(v >= vss && v < vss + c.vsync);
            p.fs = (h == 0 && v == 0);
            if (h < c.hvis && v < c.vvis) p.rgb = color(c, h, v);
        end
        return p;
    endfunction

    function automatic pins_t get_pins(int i);
        pins_t p;
        case (i)
            0:       p = {vi0.hcoord, vi0.vcoord, vi0.hsync, vi0.vsync, vi0.frame_start, vi0.vga_r, vi0.vga_g, vi0.vga_b};
            1:       p = {vi1.hcoord, vi1.vcoord, vi1.hsync, vi1.vsync, vi1.frame_start, vi1.vga_r, vi1.vga_g, vi1.vga_b};
            2:       p = {vi3.hcoord, vi3.vcoord, vi3.hsync, vi3.vsync, vi3.frame_start, vi3.vga_r, vi3.vga_g, vi3.vga_b};
            default: p = {vif.hcoord, vif.vcoord, vif.hsync, vif.vsync, vif.frame_start, vif.vga_r, vif.vga_g, vif.vga_b};
        endcase
        return p;
    endfunction

    function automatic tv_t mk(int kk, int h, int v, bit hs, bit vs, bit fs, logic [11:0] rgb);
        tv_t t;
        t.k       = kk;
        t.exp.h   = 10'(h);
        t.exp.v   = 10'(v);
        t.exp.hs  = hs;
        t.exp.vs  = vs;
        t.exp.fs  = fs;
        t.exp.rgb = rgb;
        return t;
    endfunction

    task automatic check_pins(input string name, input pins_t act, input pins_t exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d: got h=%0d v=%0d hs=%0b vs=%0b fs=%0b rgb=%h, want h=%0d v=%0d hs=%0b vs=%0b fs=%0b rgb=%h",
                     name, k, act.h, act.v, act.hs, act.vs, act.fs, act.rgb,
                     exp.h, exp.v, exp.hs, exp.vs, exp.fs, exp.rgb);
        end
    endtask

    task automatic check_cnt(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Controller stand-in: CSEL for the coming cycle is the colour of the coordinate lat clocks back.
    task automatic drive_csel();
        logic [11:0] col [4];
        int          m;
        for (int i = 0; i < 4; i++) begin
            m = k + 1 - cfg[i].lat;
            if (m < 0) m = 0;
            col[i] = color(cfg[i], m % htot(cfg[i]), (m / htot(cfg[i])) % vtot(cfg[i]));
        end
        vi0.csel = col[0];
        vi1.csel = col[1];
        vi3.csel = col[2];
        vif.csel = col[3];
    endtask

    task automatic step(input bit rst);
        srst = rst;
        @(posedge clk);
        #1;
        k = rst ? -1 : k + 1;
        drive_csel();
        for (int i = 0; i < 4; i++) check_pins(names[i], get_pins(i), model(cfg[i], k));
    endtask

    initial begin
        int    fs_cnt [3];
        int    vs_lo [3];
        int    hs_lo [3];
        int    cnt;
        int    hl;
        int    ff;
        pins_t rst_pins;

        n_vec    = 0;
        n_bad    = 0;
        k        = -1;
        srst     = 1'b1;
        cfg[0]   = '{16, 4, 6, 6, 6, 2, 2, 3, 0, 1'b1};
        cfg[1]   = '{16, 4, 6, 6, 6, 2, 2, 3, 1, 1'b1};
        cfg[2]   = '{16, 4, 6, 6, 6, 2, 2, 3, 3, 1'b1};
        cfg[3]   = '{H_VIS, H_FP, H_SYNC, H_BP, V_VIS, V_FP, V_SYNC, V_BP, 1, 1'b0};
        names[0] = "lat0";
        names[1] = "lat1";
        names[2] = "lat3";
        names[3] = "full";
        drive_csel();

        // Full-size instance, CSEL_LAT=1, CSEL tied 12'hFFF: hand-derived checkpoints.
        tbl[0]  = mk(0,   1,   0, 1, 1, 0, 12'h000);
        tbl[1]  = mk(1,   2,   0, 1, 1, 1, 12'hFFF);
        tbl[2]  = mk(2,   3,   0, 1, 1, 0, 12'hFFF);
        tbl[3]  = mk(640, 641, 0, 1, 1, 0, 12'hFFF);
        tbl[4]  = mk(641, 642, 0, 1, 1, 0, 12'h000);
        tbl[5]  = mk(656, 657, 0, 1, 1, 0, 12'h000);
        tbl[6]  = mk(657, 658, 0, 0, 1, 0, 12'h000);
        tbl[7]  = mk(752, 753, 0, 0, 1, 0, 12'h000);
        tbl[8]  = mk(753, 754, 0, 1, 1, 0, 12'h000);
        tbl[9]  = mk(798, 799, 0, 1, 1, 0, 12'h000);
        tbl[10] = mk(799, 0,   1, 1, 1, 0, 12'h000);
        tbl[11] = mk(800, 1,   1, 1, 1, 0, 12'h000);
        tbl[12] = mk(801, 2,   1, 1, 1, 0, 12'hFFF);

        repeat (3) step(1'b1);
        for (int i = 0; i < 13; i++) begin
            while (k < tbl[i].k) step(1'b0);
            check_pins($sformatf("tbl%0d", i), get_pins(3), tbl[i].exp);
        end

        // One full line on the full-size instance: 96 sync clocks, 640 lit pixels.
        hl = 0;
        ff = 0;
        repeat (800) begin
            step(1'b0);
            if (vif.hsync == 1'b0) hl++;
            if ({vif.vga_r, vif.vga_g, vif.vga_b} == 12'hFFF) ff++;
        end
        check_cnt("full_hsync_low_per_line", hl, 96);
        check_cnt("full_lit_per_line", ff, 640);

        // One whole small frame from reset: single frame tick, 2 lines of vsync, 6 hsync clocks per line.
        step(1'b1);
        for (int i = 0; i < 3; i++) begin
            fs_cnt[i] = 0;
            vs_lo[i]  = 0;
            hs_lo[i]  = 0;
        end
        repeat (416) begin
            step(1'b0);
            for (int i = 0; i < 3; i++) begin
                if (get_pins(i).fs) fs_cnt[i]++;
                if (!get_pins(i).vs) vs_lo[i]++;
                if (!get_pins(i).hs) hs_lo[i]++;
            end
        end
        for (int i = 0; i < 3; i++) begin
            check_cnt({names[i], "_frame_ticks"}, fs_cnt[i], 1);
            check_cnt({names[i], "_vsync_low"}, vs_lo[i], 64);
            check_cnt({names[i], "_hsync_low"}, hs_lo[i], 78);
        end

        // Reset while counters sit inside both sync regions of the small timing (h=23, v=9).
        cnt = 0;
        while (((k + 1) % 416) != 311 && cnt < 2000) begin
            step(1'b0);
            cnt++;
        end
        check_cnt("reach_mid_sync", cnt < 2000 ? 1 : 0, 1);
        step(1'b1);
        rst_pins = {10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 12'h000};
        for (int i = 0; i < 3; i++) check_pins({names[i], "_mid_reset"}, get_pins(i), rst_pins);
        repeat (80) step(1'b0);

        // Random reset timing; every clock is still compared against the model.
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(600, 20)) step(1'b0);
            repeat ($urandom_range(3, 1)) step(1'b1);
        end
        repeat (40) step(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
